// File: rtl/qc_pkg.sv
// Shared types and constants for the quantum-state emulator datapath:
// sign-magnitude complex amplitudes, probability width and LFSR defaults.
package qc_pkg;

   localparam int          QW        = 8;
   localparam int          QFRAC     = 6;
   localparam logic [7:0]  Q_ONE     = 8'(1 << QFRAC);
   localparam int          PROB_W    = 15;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // Galois taps for x^16+x^14+x^13+x^11+1 in right-shift form
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef struct packed {
      logic [QW-1:0] a;
      logic [QW-1:0] b;
   } complexNum;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } meas_state_t;

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      logic [15:0] nxt;
      nxt = {1'b0, v[15:1]};
      if (v[0]) begin
         nxt = nxt ^ LFSR_TAPS;
      end else begin
         nxt = nxt;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/state_measure_if.sv
// Handshake and data bundle between a measurement requester and state_measure.
interface state_measure_if #(
   parameter int N = 2
);
   import qc_pkg::*;

   logic                       start;
   complexNum [(1<<N)-1:0]     state_in;
   logic                       seed_we;
   logic [15:0]                seed;
   logic                       busy;
   logic                       done;
   logic [N-1:0]               result;
   logic [PROB_W-1:0]          prob;
   logic                       norm_err;
   complexNum [(1<<N)-1:0]     collapsed;

   modport master (
      output start, state_in, seed_we, seed,
      input  busy, done, result, prob, norm_err, collapsed
   );

   modport slave (
      input  start, state_in, seed_we, seed,
      output busy, done, result, prob, norm_err, collapsed
   );

endinterface

// File: rtl/amp_prob.sv
// Squared magnitude of one sign-magnitude complex amplitude; the two 6-bit
// fractions square to exactly 12 fractional bits, so 1.0 comes out as 4096.
module amp_prob
   import qc_pkg::*;
(
   input  complexNum         amp,
   output logic [PROB_W-1:0] p
);

   logic [13:0] ma_s;
   logic [13:0] mb_s;
   logic [13:0] sqa_s;
   logic [13:0] sqb_s;

   // Sign bits are dropped; 127^2 still fits in 14 bits, the sum in 15
   always_comb begin
      ma_s  = {7'd0, amp.a[QW-2:0]};
      mb_s  = {7'd0, amp.b[QW-2:0]};
      sqa_s = ma_s * ma_s;
      sqb_s = mb_s * mb_s;
      p     = {1'b0, sqa_s} + {1'b0, sqb_s};
   end

endmodule

// File: rtl/state_measure.sv
// Born-rule sampler: scans the latched state vector one amplitude per cycle,
// picks the first index whose cumulative probability exceeds an LFSR threshold
// and reports the index, its probability and the collapsed basis state.
module state_measure
   import qc_pkg::*;
#(
   parameter int          N    = 2,
   parameter logic [15:0] SEED = LFSR_SEED
) (
   input logic            clk,
   input logic            reset,
   state_measure_if.slave bus
);

   localparam int           NAMP   = 1 << N;
   localparam int           CW     = PROB_W + N;
   localparam logic [N-1:0] K_LAST = N'(NAMP - 1);

   meas_state_t              state_r, state_n;
   logic [N-1:0]             k_r, k_n;
   complexNum [NAMP-1:0]     lat_r, lat_n;
   logic [11:0]              r_r, r_n;
   logic [CW-1:0]            cum_r, cum_n;
   logic                     hit_r, hit_n;
   logic [N-1:0]             hit_idx_r, hit_idx_n;
   logic [PROB_W-1:0]        hit_p_r, hit_p_n;
   logic                     nz_r, nz_n;
   logic [N-1:0]             nz_idx_r, nz_idx_n;
   logic [PROB_W-1:0]        nz_p_r, nz_p_n;
   logic [15:0]              lfsr_r, lfsr_n;
   logic                     busy_r, busy_n;
   logic                     done_r, done_n;
   logic [N-1:0]             result_r, result_n;
   logic [PROB_W-1:0]        prob_r, prob_n;
   logic                     norm_err_r, norm_err_n;
   complexNum [NAMP-1:0]     collapsed_r, collapsed_n;

   complexNum                amp_s;
   logic [PROB_W-1:0]        p_s;
   logic [CW-1:0]            cum_sum_s;
   logic [15:0]              load_s;
   logic [N-1:0]             sel_idx_s;
   logic [PROB_W-1:0]        sel_p_s;

   assign amp_s = lat_r[k_r];

   amp_prob u_amp_prob (
      .amp (amp_s),
      .p   (p_s)
   );

   // Next-state, scan bookkeeping and output staging
   always_comb begin
      state_n     = state_r;
      k_n         = k_r;
      lat_n       = lat_r;
      r_n         = r_r;
      cum_n       = cum_r;
      hit_n       = hit_r;
      hit_idx_n   = hit_idx_r;
      hit_p_n     = hit_p_r;
      nz_n        = nz_r;
      nz_idx_n    = nz_idx_r;
      nz_p_n      = nz_p_r;
      lfsr_n      = lfsr_r;
      busy_n      = busy_r;
      done_n      = 1'b0;
      result_n    = result_r;
      prob_n      = prob_r;
      norm_err_n  = norm_err_r;
      collapsed_n = collapsed_r;
      sel_idx_s   = N'(0);
      sel_p_s     = PROB_W'(0);
      load_s      = (bus.seed == 16'h0000) ? LFSR_SEED : bus.seed;
      cum_sum_s   = cum_r + CW'(p_s);

      case (state_r)
         ST_IDLE: begin
            if (bus.start) begin
               state_n   = ST_SCAN;
               busy_n    = 1'b1;
               lat_n     = bus.state_in;
               k_n       = N'(0);
               cum_n     = CW'(0);
               hit_n     = 1'b0;
               hit_idx_n = N'(0);
               hit_p_n   = PROB_W'(0);
               nz_n      = 1'b0;
               nz_idx_n  = N'(0);
               nz_p_n    = PROB_W'(0);
               // A same-cycle seed load supplies r and suppresses the advance
               if (bus.seed_we) begin
                  r_n    = load_s[11:0];
                  lfsr_n = load_s;
               end else begin
                  r_n    = lfsr_r[11:0];
                  lfsr_n = lfsr_step(lfsr_r);
               end
            end else if (bus.seed_we) begin
               lfsr_n = load_s;
            end else begin
               lfsr_n = lfsr_r;
            end
         end

         ST_SCAN: begin
            cum_n = cum_sum_s;
            k_n   = k_r + N'(1);
            if (!hit_r && (cum_sum_s > CW'(r_r))) begin
               hit_n     = 1'b1;
               hit_idx_n = k_r;
               hit_p_n   = p_s;
            end else begin
               hit_n     = hit_r;
            end
            if (p_s != PROB_W'(0)) begin
               nz_n     = 1'b1;
               nz_idx_n = k_r;
               nz_p_n   = p_s;
            end else begin
               nz_n     = nz_r;
            end
            // Final amplitude: results are staged so they appear with done
            if (k_r == K_LAST) begin
               state_n = ST_DONE;
               done_n  = 1'b1;
               if (hit_n) begin
                  sel_idx_s = hit_idx_n;
                  sel_p_s   = hit_p_n;
               end else if (nz_n) begin
                  sel_idx_s = nz_idx_n;
                  sel_p_s   = nz_p_n;
               end else begin
                  sel_idx_s = N'(0);
                  sel_p_s   = PROB_W'(0);
               end
               result_n   = sel_idx_s;
               prob_n     = sel_p_s;
               norm_err_n = ~hit_n;
               for (int i = 0; i < NAMP; i++) begin
                  collapsed_n[i] = (i == int'(sel_idx_s)) ? {Q_ONE, 8'h00} : 16'h0000;
               end
            end else begin
               state_n = ST_SCAN;
            end
         end

         ST_DONE: begin
            state_n = ST_IDLE;
            busy_n  = 1'b0;
         end

         default: begin
            state_n = ST_IDLE;
            busy_n  = 1'b0;
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_n;
      end
   end

   // Datapath, LFSR and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         k_r         <= N'(0);
         lat_r       <= '0;
         r_r         <= 12'h000;
         cum_r       <= CW'(0);
         hit_r       <= 1'b0;
         hit_idx_r   <= N'(0);
         hit_p_r     <= PROB_W'(0);
         nz_r        <= 1'b0;
         nz_idx_r    <= N'(0);
         nz_p_r      <= PROB_W'(0);
         lfsr_r      <= SEED;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         result_r    <= N'(0);
         prob_r      <= PROB_W'(0);
         norm_err_r  <= 1'b0;
         collapsed_r <= '0;
      end else begin
         k_r         <= k_n;
         lat_r       <= lat_n;
         r_r         <= r_n;
         cum_r       <= cum_n;
         hit_r       <= hit_n;
         hit_idx_r   <= hit_idx_n;
         hit_p_r     <= hit_p_n;
         nz_r        <= nz_n;
         nz_idx_r    <= nz_idx_n;
         nz_p_r      <= nz_p_n;
         lfsr_r      <= lfsr_n;
         busy_r      <= busy_n;
         done_r      <= done_n;
         result_r    <= result_n;
         prob_r      <= prob_n;
         norm_err_r  <= norm_err_n;
         collapsed_r <= collapsed_n;
      end
   end

   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
   assign bus.result    = result_r;
   assign bus.prob      = prob_r;
   assign bus.norm_err  = norm_err_r;
   assign bus.collapsed = collapsed_r;

endmodule

// File: tb/tb_state_measure.sv
// Randomised and directed bench for state_measure (N=2) against a Born-rule
// reference model with its own LFSR derived from the polynomial exponents.
module tb_state_measure;
   import qc_pkg::*;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   logic [15:0]       m_lfsr;
   logic [15:0]       m_taps;
   complexNum [3:0]   vone, vuni, vneg, vsub, vzero, vr;
   int                next_acc;
   int                dq[$];
   int                rq[$];
   int                pq[$];

   state_measure_if #(.N(2)) bus ();

   state_measure #(.N(2), .SEED(16'hACE1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Multiply-by-x modulo the polynomial, taps derived from its exponents
   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      logic [15:0] n;
      n = v >> 1;
      if (v[0]) n = n ^ m_taps;
      return n;
   endfunction

   function automatic void ref_measure(input complexNum [3:0] v, input int r,
                                       output int res, output int pr, output bit nerr);
      int p[4];
      int cum;
      bit hit;
      cum = 0; hit = 0; res = 0; pr = 0;
      for (int k = 0; k < 4; k++) begin
         p[k] = int'(v[k].a[6:0]) * int'(v[k].a[6:0]) + int'(v[k].b[6:0]) * int'(v[k].b[6:0]);
      end
      for (int k = 0; k < 4; k++) begin
         cum += p[k];
         if (!hit && cum > r) begin
            hit = 1; res = k; pr = p[k];
         end
      end
      if (!hit) begin
         for (int k = 0; k < 4; k++) begin
            if (p[k] != 0) begin
               res = k; pr = p[k];
            end
         end
      end
      nerr = !hit;
   endfunction

   function automatic logic [63:0] exp_collapse(input int idx);
      logic [63:0] v;
      v = 64'd0;
      v[idx*16 +: 16] = 16'h4000;
      return v;
   endfunction

   task automatic measure(input complexNum [3:0] v, input bit do_seed,
                          input logic [15:0] sd, input bit noise);
      int          r, er, ep, cyc;
      bit          en;
      logic [15:0] ld;
      bus.start    = 1'b1;
      bus.state_in = v;
      bus.seed_we  = do_seed;
      bus.seed     = sd;
      if (do_seed) begin
         ld     = (sd == 16'h0000) ? 16'hACE1 : sd;
         m_lfsr = ld;
         r      = int'(ld[11:0]);
      end else begin
         r      = int'(m_lfsr[11:0]);
         m_lfsr = lfsr_next(m_lfsr);
      end
      ref_measure(v, r, er, ep, en);
      @(posedge clk); #1;
      cyc = 1;
      bus.start   = noise;
      bus.seed_we = noise;
      bus.seed    = 16'($urandom);
      for (int k = 0; k < 4; k++) bus.state_in[k] = 16'($urandom);
      check("busy_scan", bus.busy, 1);
      while (!bus.done && cyc < 12) begin
         @(posedge clk); #1;
         cyc++;
         bus.start   = noise && (cyc < 5);
         bus.seed_we = noise && (cyc < 5);
      end
      bus.start   = 1'b0;
      bus.seed_we = 1'b0;
      check("latency", cyc, 5);
      check("result", bus.result, er);
      check("prob", bus.prob, ep);
      check("norm_err", bus.norm_err, en);
      check("collapsed", bus.collapsed, exp_collapse(er));
      @(posedge clk); #1;
      check("done_pulse", bus.done, 0);
      check("busy_idle", bus.busy, 0);
      check("hold_result", bus.result, er);
   endtask

   initial begin
      int er, ep, r;
      bit en;
      int exps[4];
      total = 0; bad = 0;
      exps = '{16, 14, 13, 11};
      m_taps = 16'h0000;
      foreach (exps[i]) m_taps[exps[i]-1] = 1'b1;
      m_lfsr = 16'hACE1;
      reset = 1'b0;
      bus.start = 1'b0; bus.seed_we = 1'b0; bus.seed = 16'h0000; bus.state_in = '0;
      vone = '0; vone[2] = {8'h40, 8'h00};
      vzero = '0;
      for (int k = 0; k < 4; k++) begin
         vuni[k] = {8'h20, 8'h00};
         vneg[k] = {8'hA0, 8'h00};
         vsub[k] = {8'h10, 8'h00};
      end

      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_result", bus.result, 0);
      check("rst_prob", bus.prob, 0);
      check("rst_norm_err", bus.norm_err, 0);
      check("rst_collapsed", bus.collapsed, 0);
      @(posedge clk); #1;

      measure(vone, 0, 16'h0000, 0);
      measure(vuni, 1, 16'h03FF, 0);
      measure(vuni, 1, 16'h0400, 0);
      measure(vuni, 1, 16'h0FFF, 0);
      measure(vneg, 1, 16'h03FF, 0);
      measure(vneg, 1, 16'h0400, 0);
      measure(vneg, 1, 16'h0FFF, 0);
      measure(vsub, 1, 16'h0800, 0);
      measure(vzero, 0, 16'h0000, 0);
      measure(vuni, 1, 16'h0000, 0);
      measure(vuni, 0, 16'h0000, 1);
      measure(vuni, 0, 16'h0000, 0);

      for (int it = 0; it < 24; it++) begin
         for (int k = 0; k < 4; k++) begin
            vr[k] = 16'($urandom);
            if ($urandom_range(0, 2) == 0) vr[k] = vr[k] & 16'h9F9F;
            if ($urandom_range(0, 5) == 0) vr[k] = 16'h0000;
         end
         measure(vr, $urandom_range(0, 2) == 0, 16'($urandom), $urandom_range(0, 3) == 0);
      end

      // start held high: accepted every 6 cycles, r follows the model LFSR
      bus.seed_we = 1'b1; bus.seed = 16'hACE1;
      @(posedge clk); #1;
      bus.seed_we = 1'b0;
      m_lfsr = 16'hACE1;
      next_acc = 0;
      bus.state_in = vuni;
      for (int c = 0; c < 30; c++) begin
         bus.start = (c < 20);
         if (c == next_acc && c < 20) begin
            r = int'(m_lfsr[11:0]);
            m_lfsr = lfsr_next(m_lfsr);
            ref_measure(vuni, r, er, ep, en);
            dq.push_back(c + 5); rq.push_back(er); pq.push_back(ep);
            next_acc = c + 6;
         end
         check("held_done", bus.done, (dq.size() > 0 && dq[0] == c));
         if (dq.size() > 0 && dq[0] == c) begin
            check("held_result", bus.result, rq[0]);
            check("held_prob", bus.prob, pq[0]);
            void'(dq.pop_front()); void'(rq.pop_front()); void'(pq.pop_front());
         end
         @(posedge clk); #1;
      end
      bus.start = 1'b0;
      check("held_all_seen", dq.size(), 0);

      // reset during SCAN cycle 2 aborts the measurement
      measure(vone, 0, 16'h0000, 0);
      bus.start = 1'b1; bus.state_in = vuni;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      check("abort_busy", bus.busy, 0);
      check("abort_done", bus.done, 0);
      check("abort_result", bus.result, 0);
      check("abort_prob", bus.prob, 0);
      check("abort_norm_err", bus.norm_err, 0);
      check("abort_collapsed", bus.collapsed, 0);
      m_lfsr = 16'hACE1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      for (int c = 0; c < 8; c++) begin
         check("abort_no_done", bus.done, 0);
         @(posedge clk); #1;
      end
      measure(vuni, 0, 16'h0000, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

endmodule

// File: doc/state_measure.md
# state_measure

Sequential measurement unit for the emulator's output side. It consumes the 2^N-amplitude complex state vector produced by the gate/state multiplier and samples one computational-basis outcome with the Born rule, using a 16-bit LFSR as its random source. It returns the measured index, that outcome's probability and the collapsed state vector, ready to feed back as the next `state` operand.

## Interface
- `N`, default 2: qubit count; 2^N amplitudes.
- `SEED`, default 16'hACE1: LFSR reset value; must be nonzero.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `start`  in  1: request a measurement; accepted only in IDLE.
- `state_in`  in  complexNum[2^N]: amplitudes; sampled on the accepted `start` cycle.
- `seed_we`  in  1: load `seed` into the LFSR; honoured only in IDLE.
- `seed`  in  16: new LFSR value; 16'h0000 loads 16'hACE1 instead.
- `busy`  out  1: high in SCAN and DONE.
- `done`  out  1: one-cycle pulse when the results update.
- `result`  out  N: measured basis index.
- `prob`  out  15: probability of `result`, unsigned, 12 fractional bits.
- `norm_err`  out  1: no cumulative sum exceeded the threshold.
- `collapsed`  out  complexNum[2^N]: post-measurement state.

## Operation
- Number format: each component is 8-bit sign-magnitude. Bit 7 is the sign; bits 6:0 are the magnitude, scaled by 1/64. 1.0 = 8'h40.
- Probability: p_k = mag(a)^2 + mag(b)^2. The result is 15 bits with 12 fractional bits, so 1.0 = 4096. The sign bit is ignored.
- Threshold: r = LFSR[11:0], captured when `start` is accepted, with range [0, 4096).
- LFSR: Galois, polynomial x^16+x^14+x^13+x^11+1. It advances exactly once per accepted `start`.
- LFSR load: `seed_we` in IDLE loads the LFSR. If `start` is in the same cycle, r is taken from the loaded value and the LFSR does not advance that cycle.
- FSM states:
  - IDLE: `start` latches `state_in`, captures r, clears the accumulator, then goes to SCAN.
  - SCAN: one amplitude per cycle, k = 0..2^N-1. cum += p_k. The first k with cum > r is recorded as the hit. After k = 2^N-1, go to DONE.
  - DONE: drive the outputs, pulse `done`, return to IDLE.
- Accumulator: 15+N bits; it never saturates.
- Selection order:
  - If there is a hit, `result` = the hit index and `norm_err` = 0.
  - Otherwise `result` = the last k with p_k ≠ 0 and `norm_err` = 1.
  - If every p_k = 0, `result` = 0 and `norm_err` = 1.
- Collapse: `collapsed[result]` = {a: 8'h40, b: 8'h00}. Every other entry is {0, 0}; global phase is discarded.
- `start` outside IDLE: ignored; no LFSR advance. `seed_we` outside IDLE: ignored.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0, `prob`=0, `norm_err`=0, all `collapsed` entries zero, LFSR=`SEED`, FSM=IDLE.
- `start` accepted at cycle 0: SCAN occupies cycles 1..2^N, and `done`, `result`, `prob`, `norm_err` and `collapsed` update in cycle 2^N+1. With N=2, `done` rises in cycle 5.
- Outputs hold their values until the next `done`.
- Minimum start-to-start interval is 2^N+2 cycles. If `start` is held high, a new measurement is accepted on the cycle after DONE.
- Latency is fixed and does not depend on data or on where the hit occurs.
- Reset asserted mid-operation returns everything to the reset values immediately. The aborted measurement produces no `done`.

## Structure
- Shared package `qc_pkg`:
  - `complexNum` typedef.
  - Constants: `QW`=8, `QFRAC`=6, `Q_ONE`=8'h40, `PROB_W`=15.
  - LFSR default seed.
- Sub-module `amp_prob`: combinational, complexNum → 15-bit p; one instance is used by SCAN.
- The FSM, LFSR, accumulator and output registers live in `state_measure`.

## Test plan
- N=2, only amplitude 2 = {8'h40, 0}, any seed → `result`=2, `prob`=4096, `norm_err`=0, `collapsed[2]`={40,00}, `done` in cycle 5.
- Uniform amplitudes 8'h20, using `seed_we` to load r:
  - r=12'h3FF → `result`=0.
  - r=12'h400 → `result`=1.
  - r=12'hFFF → `result`=3.
  - Every case gives `prob`=1024.
- Amplitudes 8'hA0 (−0.5) with the same seeds as the uniform case → identical results, confirming the sign is ignored.
- Sub-normalised state, all amplitudes 8'h10, r=12'h800 → `result`=3, `norm_err`=1, `prob`=256. All-zero state → `result`=0, `norm_err`=1.
- `start` held high for 20 cycles with seed 16'hACE1 → accepted every 6 cycles. Each r matches a reference LFSR model, and `start` pulses while busy cause no advance.
- `reset` driven low in SCAN cycle 2 → all outputs return to reset values, no `done` pulse, LFSR=`SEED`. The next `start` completes normally.
